data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the processor's load/store interface (MemRead/MemWrite, address, write data, read data).
- Adds a valid/ready request–response handshake and a configurable wait-state latency, so the pipelined core can be tested against realistic memory timing.
- Stores 64-bit doublewords, byte-addressed, aligned accesses only.
- Reports misaligned and out-of-range accesses as errors.

---
 rtl/data_mem_responder.sv | 100 ++++++++++
 tb/tb_data_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: valid/ready request and
// response handshakes, fixed wait-state latency, aligned 64-bit doubleword storage.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    // One extra count beyond the wait states: the access itself takes an edge.
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic           r_write;
    logic [63:0]    r_addr, r_wdata;
    logic           r_req_ready, r_rsp_valid, r_rsp_err;
    logic [63:0]    r_rsp_rdata;
    logic [63:0]    r_mem [DEPTH_WORDS] = '{default: '0};

    logic           w_accept, w_access, w_err;
    logic [AW-1:0]  w_idx;

    assign w_accept = (r_state == IDLE) && req_valid && r_req_ready;
    assign w_access = (r_state == WAIT) && (r_cnt == CW'(1));
    // Full-width compare so high address bits never alias into the array.
    assign w_err    = (r_addr[2:0] != 3'd0) || (r_addr[63:3] >= 61'(DEPTH_WORDS));
    assign w_idx    = r_addr[AW+2:3];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: if (w_accept) begin
                w_next     = WAIT;
                w_cnt_next = CNT_INIT;
            end
            WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_next = RESP;
            end
            RESP: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_req_ready <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            if (w_access) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_write) ? '0 : r_mem[w_idx];
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Commit only on the access edge, so a reset during WAIT drops the store.
    always_ff @(posedge clk) begin
        if (reset && w_access && r_write && !w_err) r_mem[w_idx] <= r_wdata;
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) share one request bus,
// selected by sel; expected responses come from a local memory model.
module tb_data_mem_responder;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_write, rsp_ready, sel;
    logic [63:0] req_addr, req_wdata;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [63:0] a_rsp_rdata, b_rsp_rdata;
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [63:0] w_rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

    assign w_req_ready = sel ? b_req_ready : a_req_ready;
    assign w_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign w_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign w_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t     sb[$];
    bit [63:0] model [2][DEPTH];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the DUT idle.
    task automatic send(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                        input int stall);
        exp_t        e, g;
        bit          err;
        int          idx, n;
        logic [63:0] held;
        err = (addr[2:0] != 3'd0) || ((addr >> 3) >= 64'(DEPTH));
        idx = err ? 0 : int'(addr[31:3]);
        e.err   = err;
        e.rdata = (wr || err) ? 64'd0 : model[sel][idx];
        e.lat   = (sel ? 0 : 2) + 2;
        if (wr && !err) model[sel][idx] = wd;
        sb.push_back(e);

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        chk("req_ready_before_accept", w_req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

        n = 0;
        do begin
            @(negedge clk); n++;
            if (!w_rsp_valid) chk("busy_req_ready", w_req_ready, 0);
        end while (!w_rsp_valid && n < 30);
        g = sb.pop_front();
        if (!w_rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("latency", n, g.lat);
        chk("rsp_rdata", w_rsp_rdata, g.rdata);
        chk("rsp_err", w_rsp_err, g.err);
        held = w_rsp_rdata;

        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hFFFF;
            @(negedge clk);
            chk("stall_valid", w_rsp_valid, 1);
            chk("stall_rdata", w_rsp_rdata, held);
            chk("stall_req_ready", w_req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", w_rsp_valid, 0);
        chk("release_req_ready", w_req_ready, 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_req_ready", a_req_ready, 1);
            chk("rst_rsp_valid", a_rsp_valid, 0);
            chk("rst_rsp_rdata", a_rsp_rdata, 0);
            chk("rst_rsp_err", a_rsp_err, 0);
        end
        chk("rst_b_req_ready", b_req_ready, 1);
        chk("rst_b_rsp_valid", b_rsp_valid, 0);

        send(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 0);
        send(1'b0, 64'h40, 64'h0, 0);
        send(1'b0, 64'h44, 64'h0, 0);
        send(1'b1, 64'h400, 64'h55, 0);
        send(1'b0, 64'h0, 64'h0, 0);
        send(1'b0, 64'h1000_0000_0000_0040, 64'h0, 0);
        send(1'b1, 64'h3F8, 64'h0123_4567_89AB_CDEF, 0);
        send(1'b0, 64'h3F8, 64'h0, 0);
        send(1'b0, 64'h40, 64'h0, 5);
        send(1'b0, 64'h10, 64'h0, 0);

        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8; req_wdata = 64'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_rsp_valid", a_rsp_valid, 0);
            chk("midrst_req_ready", a_req_ready, 1);
        end
        send(1'b0, 64'h8, 64'h0, 0);
        send(1'b0, 64'h40, 64'h0, 0);

        sel = 1'b1;
        send(1'b0, 64'h40, 64'h0, 0);
        for (int i = 0; i < 8; i++) begin
            send(1'(i % 2 == 0), {57'd0, 4'($urandom_range(0, 15)), 3'b000},
                 {$urandom, $urandom}, 0);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b0, {57'd0, 4'(i), 3'b000}, 64'h0, 0);
        end
        send(1'b0, 64'h3, 64'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
